vga_mode_ctrl: RTL
==================

# vga_mode_ctrl

Frame-synchronous controller that produces the 4-bit select word for the VGA output mux. Collects user requests from two push-buttons plus an auto-cycle (demo) mode into a shadow register. Commits that register to the mux only at a frame boundary, so the displayed layer never changes mid-frame. Sits between the button/switch inputs and the video mux select input in the top level.

## Interface

Parameters:
- `AUTO_FRAMES`, default 120: frames between automatic video-mode advances (≥2).

Ports (one clock; reset is synchronous and active-high):
- `clk_in` input 1: pixel clock.
- `rst_in` input 1: synchronous, active-high reset.
- `btn_video_in` input 1: level; rising edge advances video mode (sel bits [1:0]).
- `btn_overlay_in` input 1: level; rising edge advances overlay (sel bits [3:2]).
- `test_en_in` input 1: permits overlay 3 (test color).
- `auto_in` input 1: level; enables auto-cycling of video mode.
- `new_frame_in` input 1: one-cycle pulse at start of vertical blanking.
- `sel_out` output 4: active select word to the mux, as {overlay, video}.
- `pending_out` output 1: shadow ≠ active (a change is waiting for the frame boundary).

## Operation

Registers:
- `shadow_vid[1:0]`, `shadow_ovl[1:0]`: requested mode.
- `sel_out[3:0]`: active mode.
- `btn_prev[1:0]`: edge detection.
- `frame_cnt`: width $clog2(AUTO_FRAMES).

Reset values:
- `shadow_vid`, `shadow_ovl`, `sel_out` = 0 (camera, no overlay).
- `pending_out` = 0.
- `frame_cnt` = 0.
- `btn_prev` = 2'b11, so a button held through reset is not a press.

Edge detection:
- edge = btn & ~btn_prev.
- `btn_prev` is updated every cycle.

Video sequence:
- 0→1→2→3→0: CAM, CHANNEL, THRESH, MASK.
- Modulo-4 wrap.

Overlay sequence:
- When `test_en_in`=1: 0→1→2→3→0 (NONE, CROSSHAIR, SPRITE, TEST).
- When `test_en_in`=0: 3 is skipped, so 2→0.
- If `test_en_in` falls while `shadow_ovl`=3: `shadow_ovl` becomes 0 on the next cycle.
- In that case the active value stays 3 until the next commit.

Auto-cycle FSM, states IDLE and AUTO:
- IDLE→AUTO when `auto_in`=1.
- AUTO→IDLE when `auto_in`=0.
- `frame_cnt` is cleared on every transition and held at 0 in IDLE.
- In AUTO, on each `new_frame_in`:
  - if `frame_cnt` = AUTO_FRAMES-1: clear it and perform an auto-advance;
  - otherwise increment it.

Auto-advance:
- Sets `shadow_vid` = `shadow_vid`+1.
- On the same edge, loads `sel_out` with {`shadow_ovl`, `shadow_vid`+1}.
- No one-frame lag.

Commit:
- On `new_frame_in` (no auto-advance), `sel_out` ← {`shadow_ovl`, `shadow_vid`} as held before this cycle's button updates.

Simultaneous events:
- **Video edge during AUTO:** advances `shadow_vid` by 1 and clears `frame_cnt`.
- **Video edge and auto-advance in the same cycle:** only one advance (+1, not +2), and it is committed.
- **Button edge and `new_frame_in` in the same cycle (no auto-advance):** the commit uses the pre-edge shadow; the new request commits at the following frame, and `pending_out`=1 in between.
- **Both buttons in the same cycle:** both fields advance independently.
- **`rst_in` mid-frame or mid-count:** all registers return to reset values on that edge.

`pending_out` = ({`shadow_ovl`, `shadow_vid`} ≠ `sel_out`), computed combinationally from registers.

## Timing

- `sel_out` changes only on the clock edge at which `new_frame_in`=1; it is visible the cycle after the pulse.
- Shadow updates one edge after the button rising edge is sampled.
- Worst-case press-to-display latency: one frame plus 2 cycles.
- Buttons are assumed debounced upstream. Presses closer than 2 cycles are not guaranteed distinct.
- `new_frame_in` pulses at most once per frame. A pulse held for k cycles counts as k frames (not guarded).

## Structure

Package `vga_pkg`:
- `video_mode_t` enum: CAM=0, CHANNEL=1, THRESH=2, MASK=3.
- `overlay_t` enum: NONE=0, CROSSHAIR=1, SPRITE=2, TEST=3.
- `auto_state_t` enum: IDLE, AUTO.
- `AUTO_FRAMES_DEFAULT` = 120.

Sub-module `rise_edge`:
- 1-bit registered rising-edge detector with reset value parameter `INIT`.
- Instantiated twice, with INIT=1.

All other logic lives in `vga_mode_ctrl`.

## Test plan

- **Reset with `btn_video_in` held high, then 3 frame pulses:** `sel_out`=4'h0 throughout; no press registered.
- **Video press, no frame pulse for 100 cycles, then `new_frame_in`:** `pending_out`=1 during the wait; `sel_out` goes 0→4'h1 the cycle after the pulse; `pending_out` returns to 0.
- **Overlay presses ×3 with `test_en_in`=0, committing each frame:** overlay field 0→1→2→0, giving `sel_out` 4'h4, 4'h8, 4'h0. Repeat with `test_en_in`=1 and 4 presses: 4'h4, 4'h8, 4'hC, 4'h0.
- **`auto_in`=1 with AUTO_FRAMES=4, 17 frame pulses:** video field advances on pulses 4, 8, 12 and 16, giving 1, 2, 3, 0.
- **Video press and `new_frame_in` in the same cycle, shadow=0:** `sel_out` stays 0 and `pending_out`=1; the next pulse gives `sel_out`=4'h1.
- **`rst_in` asserted mid-count with shadow=4'hB and active=4'h6:** next cycle `sel_out`=0, `pending_out`=0, and the FSM is in IDLE.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA mux select controller.
package vga_pkg;

   typedef enum logic [1:0] {
      CAM     = 2'd0,
      CHANNEL = 2'd1,
      THRESH  = 2'd2,
      MASK    = 2'd3
   } video_mode_t;

   typedef enum logic [1:0] {
      NONE      = 2'd0,
      CROSSHAIR = 2'd1,
      SPRITE    = 2'd2,
      TEST      = 2'd3
   } overlay_t;

   typedef enum logic {
      IDLE = 1'b0,
      AUTO = 1'b1
   } auto_state_t;

   localparam int AUTO_FRAMES_DEFAULT = 120;

   // Overlay step; the test-colour layer is only reachable with test_en set.
   function automatic overlay_t next_overlay(input overlay_t cur, input logic test_en);
      overlay_t nxt;
      case (cur)
         NONE:      nxt = CROSSHAIR;
         CROSSHAIR: nxt = SPRITE;
         SPRITE:    nxt = test_en ? TEST : NONE;
         TEST:      nxt = NONE;
         default:   nxt = NONE;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/vga_mode_ctrl_rise_edge.sv
// Single-bit rising-edge detector; the history register resets to INIT so a
// level held high through reset is not seen as an edge.
module rise_edge #(
   parameter logic INIT = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);

   logic prev_r;

   // History of the input level, one cycle behind.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_r <= INIT;
      end else begin
         prev_r <= d;
      end
   end

   assign rise = d & ~prev_r;

endmodule

// File: rtl/vga_mode_ctrl.sv
// Collects button / auto-cycle requests into a shadow select and commits it to
// the video mux only on frame boundaries.
module vga_mode_ctrl
   import vga_pkg::*;
#(
   parameter int AUTO_FRAMES = AUTO_FRAMES_DEFAULT
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       btn_video_in,
   input  logic       btn_overlay_in,
   input  logic       test_en_in,
   input  logic       auto_in,
   input  logic       new_frame_in,
   output logic [3:0] sel_out,
   output logic       pending_out
);

   localparam int CNT_W = $clog2(AUTO_FRAMES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AUTO_FRAMES - 1);

   auto_state_t      state_r, state_nxt_s;
   logic [CNT_W-1:0] frame_cnt_r, frame_cnt_nxt_s;
   video_mode_t      shadow_vid_r, shadow_vid_nxt_s;
   overlay_t         shadow_ovl_r, shadow_ovl_nxt_s;
   logic [3:0]       sel_r, sel_nxt_s;
   logic             vid_rise_s, ovl_rise_s, auto_adv_s;

   rise_edge #(.INIT(1'b1)) u_vid_edge (
      .clk (clk_in), .rst (rst_in), .d (btn_video_in),   .rise (vid_rise_s)
   );
   rise_edge #(.INIT(1'b1)) u_ovl_edge (
      .clk (clk_in), .rst (rst_in), .d (btn_overlay_in), .rise (ovl_rise_s)
   );

   // Auto-cycle FSM and frame counter; a manual video press restarts the count.
   always_comb begin
      state_nxt_s     = state_r;
      frame_cnt_nxt_s = frame_cnt_r;
      auto_adv_s      = 1'b0;
      case (state_r)
         IDLE: begin
            frame_cnt_nxt_s = '0;
            if (auto_in) begin
               state_nxt_s = AUTO;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         AUTO: begin
            if (!auto_in) begin
               state_nxt_s     = IDLE;
               frame_cnt_nxt_s = '0;
            end else if (new_frame_in && (frame_cnt_r == CNT_LAST)) begin
               auto_adv_s      = 1'b1;
               frame_cnt_nxt_s = '0;
            end else if (vid_rise_s) begin
               frame_cnt_nxt_s = '0;
            end else if (new_frame_in) begin
               frame_cnt_nxt_s = frame_cnt_r + CNT_W'(1);
            end else begin
               frame_cnt_nxt_s = frame_cnt_r;
            end
         end
         default: begin
            state_nxt_s     = IDLE;
            frame_cnt_nxt_s = '0;
         end
      endcase
   end

   // Shadow request and active select; commit always uses the pre-edge shadow.
   always_comb begin
      shadow_vid_nxt_s = shadow_vid_r;
      shadow_ovl_nxt_s = shadow_ovl_r;
      sel_nxt_s        = sel_r;
      if (vid_rise_s || auto_adv_s) begin
         shadow_vid_nxt_s = video_mode_t'(shadow_vid_r + 2'd1);
      end else begin
         shadow_vid_nxt_s = shadow_vid_r;
      end
      if (ovl_rise_s) begin
         shadow_ovl_nxt_s = next_overlay(shadow_ovl_r, test_en_in);
      end else if (!test_en_in && (shadow_ovl_r == TEST)) begin
         shadow_ovl_nxt_s = NONE;
      end else begin
         shadow_ovl_nxt_s = shadow_ovl_r;
      end
      if (auto_adv_s) begin
         sel_nxt_s = {shadow_ovl_r, shadow_vid_r + 2'd1};
      end else if (new_frame_in) begin
         sel_nxt_s = {shadow_ovl_r, shadow_vid_r};
      end else begin
         sel_nxt_s = sel_r;
      end
   end

   // State registers.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_r      <= IDLE;
         frame_cnt_r  <= '0;
         shadow_vid_r <= CAM;
         shadow_ovl_r <= NONE;
         sel_r        <= 4'h0;
      end else begin
         state_r      <= state_nxt_s;
         frame_cnt_r  <= frame_cnt_nxt_s;
         shadow_vid_r <= shadow_vid_nxt_s;
         shadow_ovl_r <= shadow_ovl_nxt_s;
         sel_r        <= sel_nxt_s;
      end
   end

   assign sel_out     = sel_r;
   assign pending_out = ({shadow_ovl_r, shadow_vid_r} != sel_r);

endmodule
